instr_fetch_unit: RTL and testbench

Instruction fetch front end: produces the 32-bit instruction stream that decode and `main_control_unit` consume. Generates sequential fetch addresses, issues them to instruction memory over a valid/ready request channel, buffers in-order responses in a small FIFO, and presents instructions with their PC to decode over a valid/ready handshake. Branch and jump redirects flush the buffer and restart fetch at the target. Responses already in flight when a redirect occurs are discarded.

---
 rtl/instr_fetch_unit.sv | 143 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: credit-limited sequential fetch, in-order response buffer and
// decode handshake with redirect flush. Define IFU_BYPASS_EN for a 0-cycle response-to-decode path.
module instr_fetch_unit #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned     FIFO_DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [XLEN-1:0] imem_rsp_data_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_pc_o
);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 2;
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fifoEntry_t;

  fifoEntry_t       fifoMem [FIFO_DEPTH];
  logic [XLEN-1:0]  fetchPc;
  logic [XLEN-1:0]  rspPc;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] dropCnt;
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;

  logic [SUM_W-1:0] inFlight;
  logic [XLEN-1:0]  redirectTarget;
  logic             reqAccept;
  logic             rspStale;
  logic             rspLive;
  logic             fifoEmpty;
  logic             bypassVld;
  logic             bypassTake;
  logic             push;
  logic             pop;

  // Credit covers buffered, requested and to-be-discarded words, so the FIFO can never overflow.
  assign inFlight         = SUM_W'(count) + SUM_W'(outstanding) + SUM_W'(dropCnt);
  assign imem_req_valid_o = rst_ni && !redirect_i && (inFlight < SUM_W'(FIFO_DEPTH));
  assign imem_req_addr_o  = fetchPc;

  assign redirectTarget = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign fifoEmpty      = (count == '0);
  assign reqAccept      = imem_req_valid_o && imem_req_ready_i;
  assign rspStale       = imem_rsp_valid_i && (dropCnt != '0);
  assign rspLive        = imem_rsp_valid_i && (dropCnt == '0) && (outstanding != '0);

  // NOTE: every signal written in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    bypassVld  = 1'b0;
    bypassTake = 1'b0;
`ifdef IFU_BYPASS_EN
    bypassVld  = rspLive && fifoEmpty && !redirect_i;
    bypassTake = bypassVld && instr_ready_i;
`endif
  end

  assign push = rspLive && !bypassTake;
  assign pop  = !fifoEmpty && instr_ready_i;

  always_comb begin
    instr_valid_o = 1'b0;
    instr_o       = NOP;
    instr_pc_o    = '0;
    if (!fifoEmpty) begin
      instr_valid_o = 1'b1;
      instr_o       = fifoMem[rdPtr].instr;
      instr_pc_o    = fifoMem[rdPtr].pc;
    end else if (bypassVld) begin
      instr_valid_o = 1'b1;
      instr_o       = imem_rsp_data_i;
      instr_pc_o    = rspPc;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetchPc     <= RESET_PC;
      rspPc       <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      dropCnt     <= '0;
      rdPtr       <= '0;
      wrPtr       <= '0;
    end else if (redirect_i) begin
      // Everything still in flight becomes stale; a response landing now is already discarded.
      fetchPc     <= redirectTarget;
      rspPc       <= redirectTarget;
      count       <= '0;
      rdPtr       <= '0;
      wrPtr       <= '0;
      outstanding <= '0;
      dropCnt     <= dropCnt + outstanding - CNT_W'(rspStale || rspLive);
    end else begin
      if (reqAccept) fetchPc <= fetchPc + XLEN'(4);

      case ({reqAccept, rspLive})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: ;
      endcase

      if (rspStale) dropCnt <= dropCnt - CNT_W'(1);
      if (rspLive)  rspPc   <= rspPc + XLEN'(4);
      if (push)     wrPtr   <= wrPtr + PTR_W'(1);
      if (pop)      rdPtr   <= rdPtr + PTR_W'(1);

      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // NOTE: the buffer storage is not reset; the count and pointers alone decide what is valid.
  always_ff @(posedge clk_i) begin
    if (push && !redirect_i) begin
      fifoMem[wrPtr] <= '{instr: imem_rsp_data_i, pc: rspPc};
    end
  end

  rspExpected: assert property (@(posedge clk_i) disable iff (!rst_ni)
    imem_rsp_valid_i |-> (outstanding != '0 || dropCnt != '0));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: behavioural instruction memory with fixed latency,
// request/delivery logs and hand-derived expectations for each scenario.
module tb_instr_fetch_unit;
  typedef struct { logic [31:0] addr; int tick; } reqRec_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; int tick; } dlvRec_t;
  typedef struct { logic [31:0] addr; int due; } memRec_t;

  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IFU_BYPASS_EN
  localparam int RSP_LAT = 0;
`else
  localparam int RSP_LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rstN;
  logic        reqValid;
  logic        reqReady;
  logic [31:0] reqAddr;
  logic        rspValid;
  logic [31:0] rspData;
  logic        redirect;
  logic [31:0] redirectPc;
  logic        instrValid;
  logic        instrReady;
  logic [31:0] instr;
  logic [31:0] instrPc;

  int checks = 0;
  int errors = 0;
  int tickCnt;
  int lat;
  reqRec_t reqLog[$];
  dlvRec_t dlvLog[$];
  memRec_t memQ[$];
  logic        lastReqValid;
  logic [31:0] lastReqAddr;
  logic        lastInstrValid;
  logic [31:0] lastInstr;

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
    .clk_i            (clk),
    .rst_ni           (rstN),
    .imem_req_valid_o (reqValid),
    .imem_req_ready_i (reqReady),
    .imem_req_addr_o  (reqAddr),
    .imem_rsp_valid_i (rspValid),
    .imem_rsp_data_i  (rspData),
    .redirect_i       (redirect),
    .redirect_pc_i    (redirectPc),
    .instr_valid_o    (instrValid),
    .instr_ready_i    (instrReady),
    .instr_o          (instr),
    .instr_pc_o       (instrPc)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] memData(input logic [31:0] a);
    return a ^ 32'hCAFE_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic resetDut(input int latency, input bit checkIdle);
    rstN = 1'b0;
    reqReady = 1'b1;
    rspValid = 1'b0;
    rspData = '0;
    redirect = 1'b0;
    redirectPc = '0;
    instrReady = 1'b1;
    lat = latency;
    tickCnt = 0;
    memQ.delete();
    reqLog.delete();
    dlvLog.delete();
    repeat (2) @(negedge clk);
    if (checkIdle) begin
      check("rst_req_valid", 32'(reqValid), 32'd0);
      check("rst_req_addr", reqAddr, 32'h0000_0000);
      check("rst_instr_valid", 32'(instrValid), 32'd0);
      check("rst_instr", instr, NOP);
      check("rst_instr_pc", instrPc, 32'h0000_0000);
    end
    rstN = 1'b1;
  endtask

  // One clock cycle: sample settled outputs, clock edge, then drive the memory response.
  task automatic tick();
    bit acc;
    logic [31:0] addr;
    reqRec_t r;
    dlvRec_t d;
    memRec_t m;
    #1;
    acc = reqValid && reqReady;
    addr = reqAddr;
    lastReqValid = reqValid;
    lastReqAddr = reqAddr;
    lastInstrValid = instrValid;
    lastInstr = instr;
    if (acc) begin
      r.addr = addr; r.tick = tickCnt;
      reqLog.push_back(r);
    end
    if (instrValid && instrReady && !redirect) begin
      d.pc = instrPc; d.instr = instr; d.tick = tickCnt;
      dlvLog.push_back(d);
    end
    @(posedge clk);
    if (acc) begin
      m.addr = addr; m.due = tickCnt + lat;
      memQ.push_back(m);
    end
    tickCnt++;
    @(negedge clk);
    if (memQ.size() > 0 && memQ[0].due <= tickCnt) begin
      rspValid = 1'b1;
      rspData = memData(memQ[0].addr);
      void'(memQ.pop_front());
    end else begin
      rspValid = 1'b0;
      rspData = '0;
    end
  endtask

  function automatic int firstAfter(input int t);
    for (int i = 0; i < dlvLog.size(); i++) begin
      if (dlvLog[i].tick > t) return i;
    end
    return -1;
  endfunction

  task automatic checkDlv(input string tag, input int idx, input logic [31:0] expPc);
    bit present;
    present = (idx >= 0) && (idx < dlvLog.size());
    check({tag, "_present"}, 32'(present), 32'd1);
    if (present) begin
      check({tag, "_pc"}, dlvLog[idx].pc, expPc);
      check({tag, "_data"}, dlvLog[idx].instr, memData(expPc));
    end
  endtask

  initial begin
    int idx;
    int staleCnt;

    // Reset values, then streaming with 1-cycle memory and decode always ready.
    resetDut(1, 1'b1);
    tick();
    check("t1_first_req_valid", 32'(lastReqValid), 32'd1);
    check("t1_first_req_addr", lastReqAddr, 32'h0000_0000);
    tick();
    check("t1_latency_valid", 32'(lastInstrValid), 32'(RSP_LAT == 0));
    if (RSP_LAT != 0) check("t1_idle_nop", lastInstr, NOP);
    repeat (10) tick();
    check("t1_req_count", 32'(reqLog.size() >= 3), 32'd1);
    for (int i = 0; i < 3 && i < reqLog.size(); i++) begin
      check($sformatf("t1_req%0d_addr", i), reqLog[i].addr, 32'(4 * i));
      check($sformatf("t1_req%0d_tick", i), 32'(reqLog[i].tick), 32'(i));
    end
    for (int i = 0; i < 6; i++) begin
      checkDlv($sformatf("t1_dlv%0d", i), i, 32'(4 * i));
      if (i < dlvLog.size())
        check($sformatf("t1_dlv%0d_tick", i), 32'(dlvLog[i].tick), 32'(1 + RSP_LAT + i));
    end

    // Decode stalled for 10 cycles: exactly FIFO_DEPTH requests, then resume after the first pop.
    resetDut(1, 1'b0);
    instrReady = 1'b0;
    repeat (10) tick();
    check("t2_req_count", 32'(reqLog.size()), 32'd4);
    check("t2_req_stopped", 32'(lastReqValid), 32'd0);
    check("t2_no_dlv", 32'(dlvLog.size()), 32'd0);
    instrReady = 1'b1;
    repeat (10) tick();
    check("t2_resume_present", 32'(reqLog.size() > 4), 32'd1);
    if (reqLog.size() > 4) begin
      check("t2_resume_addr", reqLog[4].addr, 32'h0000_0010);
      check("t2_resume_tick", 32'(reqLog[4].tick), 32'd11);
    end
    for (int i = 0; i < 8; i++) checkDlv($sformatf("t2_dlv%0d", i), i, 32'(4 * i));

    // 3-cycle memory, redirect to 0x100 with three requests outstanding.
    resetDut(3, 1'b0);
    repeat (3) tick();
    redirect = 1'b1;
    redirectPc = 32'h0000_0100;
    tick();
    redirect = 1'b0;
    tick();
    check("t3_flush_valid", 32'(lastInstrValid), 32'd0);
    check("t3_target_req_valid", 32'(lastReqValid), 32'd1);
    check("t3_target_req_addr", lastReqAddr, 32'h0000_0100);
    repeat (10) tick();
    checkDlv("t3_dlv0", 0, 32'h0000_0100);
    checkDlv("t3_dlv1", 1, 32'h0000_0104);
    checkDlv("t3_dlv2", 2, 32'h0000_0108);

    // Redirect coinciding with a response and a decode pop.
    resetDut(2, 1'b0);
    repeat (3) tick();
    redirect = 1'b1;
    redirectPc = 32'h0000_0300;
    tick();
    redirect = 1'b0;
    if (RSP_LAT != 0) check("t4_pop_in_redirect", 32'(lastInstrValid), 32'd1);
    tick();
    check("t4_flush_valid", 32'(lastInstrValid), 32'd0);
    check("t4_target_req_addr", lastReqAddr, 32'h0000_0300);
    repeat (8) tick();
    idx = firstAfter(3);
    checkDlv("t4_dlv0", idx, 32'h0000_0300);
    checkDlv("t4_dlv1", (idx < 0) ? -1 : idx + 1, 32'h0000_0304);

    // Misaligned target, then back-to-back redirects where the last one wins.
    resetDut(1, 1'b0);
    redirect = 1'b1;
    redirectPc = 32'h0000_0203;
    tick();
    redirect = 1'b0;
    tick();
    check("t5_align_req_valid", 32'(lastReqValid), 32'd1);
    check("t5_align_req_addr", lastReqAddr, 32'h0000_0200);
    repeat (6) tick();
    checkDlv("t5_align_dlv0", 0, 32'h0000_0200);
    checkDlv("t5_align_dlv1", 1, 32'h0000_0204);
    redirect = 1'b1;
    redirectPc = 32'h0000_0040;
    tick();
    redirectPc = 32'h0000_0080;
    tick();
    redirect = 1'b0;
    tick();
    check("t5_b2b_req_addr", lastReqAddr, 32'h0000_0080);
    repeat (8) tick();
    idx = firstAfter(9);
    checkDlv("t5_b2b_dlv0", idx, 32'h0000_0080);
    checkDlv("t5_b2b_dlv1", (idx < 0) ? -1 : idx + 1, 32'h0000_0084);
    checkDlv("t5_b2b_dlv2", (idx < 0) ? -1 : idx + 2, 32'h0000_0088);
    staleCnt = 0;
    foreach (dlvLog[i]) begin
      if (dlvLog[i].tick >= 8 && dlvLog[i].pc < 32'h0000_0080) staleCnt++;
    end
    check("t5_b2b_no_stale", 32'(staleCnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
